// File: rtl/cam_pkg.sv
// Shared encodings for the YUV422 camera capture block: FSM states, byte-order codes, neutral chroma.
package cam_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } cam_state_e;

    localparam logic       BO_YCBYCR  = 1'b0;
    localparam logic       BO_CBYCRY  = 1'b1;
    localparam logic [7:0] CR_NEUTRAL = 8'h80;
endpackage

// File: rtl/cam_yuv422_capture_if.sv
// Camera byte bus (VSYNC/HREF/D) plus the pixel/write-address stream it is turned into.
interface cam_yuv422_capture_if #(
    parameter int ADDR_W = 19
);
    logic              VSYNC;
    logic              HREF;
    logic [7:0]        D;
    logic              pix_valid;
    logic [7:0]        Y;
    logic [7:0]        Cb;
    logic [7:0]        Cr;
    logic [ADDR_W-1:0] wr_addr;

    modport master (
        output VSYNC, HREF, D,
        input  pix_valid, Y, Cb, Cr, wr_addr
    );

    modport slave (
        input  VSYNC, HREF, D,
        output pix_valid, Y, Cb, Cr, wr_addr
    );
endinterface

// File: rtl/cam_sync_edge.sv
// Registers VSYNC/HREF once and derives rise/fall pulses from registered vs previous value.
module cam_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic vsync_i,
    input  logic href_i,
    output logic href_o,
    output logic vs_rise_o,
    output logic vs_fall_o,
    output logic hr_rise_o,
    output logic hr_fall_o
);
    logic vs_q, vs_prev_q, hr_q, hr_prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vs_q      <= 1'b0;
            vs_prev_q <= 1'b0;
            hr_q      <= 1'b0;
            hr_prev_q <= 1'b0;
        end else begin
            vs_q      <= vsync_i;
            vs_prev_q <= vs_q;
            hr_q      <= href_i;
            hr_prev_q <= hr_q;
        end
    end

    assign href_o    = hr_q;
    assign vs_rise_o = vs_q & ~vs_prev_q;
    assign vs_fall_o = ~vs_q & vs_prev_q;
    assign hr_rise_o = hr_q & ~hr_prev_q;
    assign hr_fall_o = ~hr_q & hr_prev_q;
endmodule

// File: rtl/cam_yuv422_capture.sv
// YUV422 byte-stream capture: VSYNC/HREF framing to (Y,Cb,Cr) pixels with framebuffer write addresses.
// Optional macro CAM_CAPTURE_STATS_EN adds last_line_px / last_frame_lines / frame_cnt status outputs.
module cam_yuv422_capture
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int DEC_LOG2 = 0,
    parameter int ADDR_W   = 19
) (
    input  logic                PCLK,
    input  logic                rst_n,
    cam_yuv422_capture_if.slave cam,
    input  logic                en,
    input  logic                single_shot,
    input  logic                byte_order,
    output logic                frame_done,
    output logic                busy,
    output logic                line_err,
    output logic                frame_err
`ifdef CAM_CAPTURE_STATS_EN
    ,
    output logic [10:0]         last_line_px,
    output logic [9:0]          last_frame_lines,
    output logic [7:0]          frame_cnt
`endif
);
    localparam int LINE_BYTES = 2 * H_ACTIVE;
    localparam int BW         = $clog2(LINE_BYTES + 2);
    localparam int XW         = $clog2(H_ACTIVE + 1);
    localparam int YW         = $clog2(V_ACTIVE + 1);
    localparam int DMASK      = (1 << DEC_LOG2) - 1;
    localparam logic [BW-1:0] BCNT_MAX = BW'(LINE_BYTES + 1);

    logic href_lvl, vs_rise, vs_fall, hr_rise, hr_fall;

    cam_sync_edge u_sync (
        .clk_i     (PCLK),
        .rst_ni    (rst_n),
        .vsync_i   (cam.VSYNC),
        .href_i    (cam.HREF),
        .href_o    (href_lvl),
        .vs_rise_o (vs_rise),
        .vs_fall_o (vs_fall),
        .hr_rise_o (hr_rise),
        .hr_fall_o (hr_fall)
    );

    cam_state_e        state_q;
    logic [7:0]        d_q, b0_q, b2_q, cb_q, cr_hold_q;
    logic [1:0]        phase_q;
    logic [BW-1:0]     bcnt_q;
    logic              line_ok_q;
    logic [XW-1:0]     xcnt_q;
    logic [YW-1:0]     ycnt_q;
    logic [ADDR_W-1:0] addr_q, wr_addr_q;
    logic              pix_valid_q;
    logic [7:0]        pix_y_q, pix_cb_q, pix_cr_q;
    logic              frame_done_q, busy_q, line_err_q, frame_err_q;

    logic              vs_edge, frame_start, line_ok_d, byte_take, emit, keep;
    logic [1:0]        phase_d;
    logic [BW-1:0]     bcnt_d;
    logic [7:0]        pix_y_d, pix_cb_d, pix_cr_d;

    // The byte on d_q is aligned with href_lvl; phase/count restart with the line.
    always_comb begin
        vs_edge     = vs_rise | vs_fall;
        frame_start = vs_fall && (state_q == ST_ARMED);
        phase_d     = hr_rise ? 2'd0 : phase_q;
        bcnt_d      = hr_rise ? '0 : bcnt_q;
        line_ok_d   = hr_rise ? !vs_edge : line_ok_q;
        byte_take   = href_lvl && line_ok_d && (state_q == ST_ACTIVE)
                      && (bcnt_d < BW'(LINE_BYTES)) && (ycnt_q < YW'(V_ACTIVE));
        emit        = byte_take && phase_d[0];
        keep        = emit && ((xcnt_q & XW'(DMASK)) == '0) && ((ycnt_q & YW'(DMASK)) == '0);
        if (byte_order == BO_YCBYCR) begin
            pix_y_d  = phase_d[1] ? b2_q : b0_q;
            pix_cb_d = phase_d[1] ? cb_q : d_q;
            pix_cr_d = phase_d[1] ? d_q  : cr_hold_q;
        end else begin
            pix_y_d  = d_q;
            pix_cb_d = phase_d[1] ? cb_q : b0_q;
            pix_cr_d = phase_d[1] ? b2_q : cr_hold_q;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            d_q          <= '0;
            b0_q         <= '0;
            b2_q         <= '0;
            cb_q         <= '0;
            cr_hold_q    <= CR_NEUTRAL;
            phase_q      <= '0;
            bcnt_q       <= '0;
            line_ok_q    <= 1'b0;
            xcnt_q       <= '0;
            ycnt_q       <= '0;
            addr_q       <= '0;
            wr_addr_q    <= '0;
            pix_valid_q  <= 1'b0;
            pix_y_q      <= '0;
            pix_cb_q     <= '0;
            pix_cr_q     <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            line_err_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            d_q          <= cam.D;
            pix_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;

            if (href_lvl) begin
                phase_q <= phase_d + 2'd1;
                bcnt_q  <= (bcnt_d == BCNT_MAX) ? bcnt_d : bcnt_d + 1'b1;
                if (phase_d == 2'd0) b0_q <= d_q;
                if (phase_d == 2'd2) b2_q <= d_q;
            end
            if (hr_rise) begin
                line_ok_q <= !vs_edge;
                cr_hold_q <= CR_NEUTRAL;
                xcnt_q    <= '0;
            end
            if (emit) begin
                xcnt_q <= xcnt_q + 1'b1;
                if (!phase_d[1]) cb_q      <= pix_cb_d;
                else             cr_hold_q <= pix_cr_d;
            end
            if (keep) begin
                pix_valid_q <= 1'b1;
                pix_y_q     <= pix_y_d;
                pix_cb_q    <= pix_cb_d;
                pix_cr_q    <= pix_cr_d;
                wr_addr_q   <= addr_q;
                addr_q      <= addr_q + 1'b1;
            end
            if (hr_fall && line_ok_q && !vs_edge && (state_q == ST_ACTIVE)) begin
                if (bcnt_q != BW'(LINE_BYTES)) line_err_q <= 1'b1;
                if (ycnt_q == YW'(V_ACTIVE)) frame_err_q <= 1'b1;
                else                         ycnt_q      <= ycnt_q + 1'b1;
            end
            if (frame_start) begin
                xcnt_q      <= '0;
                ycnt_q      <= '0;
                addr_q      <= '0;
                line_err_q  <= 1'b0;
                frame_err_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_q <= ST_ARMED;
                        busy_q  <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (!en) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (vs_fall) begin
                        state_q <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (vs_rise) begin
                        frame_done_q <= 1'b1;
                        busy_q       <= en && !single_shot;
                        if (!en)             state_q <= ST_IDLE;
                        else if (single_shot) state_q <= ST_DONE;
                        else                 state_q <= ST_ARMED;
                    end
                end
                ST_DONE: begin
                    if (!en) state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CAM_CAPTURE_STATS_EN
    logic [10:0] last_line_px_q;
    logic [9:0]  last_frame_lines_q;
    logic [7:0]  frame_cnt_q;

    always_ff @(posedge PCLK) begin
        if (!rst_n) begin
            last_line_px_q     <= '0;
            last_frame_lines_q <= '0;
            frame_cnt_q        <= '0;
        end else begin
            if (hr_fall && line_ok_q && !vs_edge && (state_q == ST_ACTIVE))
                last_line_px_q <= 11'(xcnt_q);
            if (vs_rise && (state_q == ST_ACTIVE)) begin
                last_frame_lines_q <= 10'(ycnt_q);
                frame_cnt_q        <= frame_cnt_q + 8'd1;
            end
        end
    end

    assign last_line_px     = last_line_px_q;
    assign last_frame_lines = last_frame_lines_q;
    assign frame_cnt        = frame_cnt_q;
`endif

    assign cam.pix_valid = pix_valid_q;
    assign cam.Y         = pix_y_q;
    assign cam.Cb        = pix_cb_q;
    assign cam.Cr        = pix_cr_q;
    assign cam.wr_addr   = wr_addr_q;
    assign frame_done    = frame_done_q;
    assign busy          = busy_q;
    assign line_err      = line_err_q;
    assign frame_err     = frame_err_q;
endmodule

// File: tb/tb_cam_yuv422_capture.sv
// Bench for cam_yuv422_capture: two instances (no decimation / DEC_LOG2=1) fed the same 4x4 camera stream.
module tb_cam_yuv422_capture;
    localparam int H  = 4;
    localparam int V  = 4;
    localparam int AW = 8;

    typedef struct packed {
        logic [7:0]    y;
        logic [7:0]    cb;
        logic [7:0]    cr;
        logic [AW-1:0] a;
    } px_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, ss = 1'b0, order = 1'b0;
    logic       vsync = 1'b1, href = 1'b0;
    logic [7:0] d = 8'd0;
    logic       fd0, fd1, busy0, busy1, le0, le1, fe0, fe1;

    cam_yuv422_capture_if #(.ADDR_W(AW)) bus0 ();
    cam_yuv422_capture_if #(.ADDR_W(AW)) bus1 ();

    assign bus0.VSYNC = vsync;
    assign bus0.HREF  = href;
    assign bus0.D     = d;
    assign bus1.VSYNC = vsync;
    assign bus1.HREF  = href;
    assign bus1.D     = d;

    cam_yuv422_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .DEC_LOG2(0), .ADDR_W(AW)) dut0 (
        .PCLK(clk), .rst_n(rst_n), .cam(bus0), .en(en), .single_shot(ss), .byte_order(order),
        .frame_done(fd0), .busy(busy0), .line_err(le0), .frame_err(fe0)
    );
    cam_yuv422_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .DEC_LOG2(1), .ADDR_W(AW)) dut1 (
        .PCLK(clk), .rst_n(rst_n), .cam(bus1), .en(en), .single_shot(ss), .byte_order(order),
        .frame_done(fd1), .busy(busy1), .line_err(le1), .frame_err(fe1)
    );

    always #5 clk = ~clk;

    int         n_chk = 0, n_fail = 0;
    px_t        q0[$], q1[$], cap0[$], cap1[$];
    px_t        g0, g1;
    logic [7:0] lb[16];
    bit         cap, exp_le, exp_fe, mon_en;
    int         line_idx, a0, a1, exp_fd, fdn0, fdn1, base0, base1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int base);
        for (int i = 0; i < 16; i++) lb[i] = 8'(base + i);
    endtask

    // Expected pixels of one line, straight from the YUV422 pairing rules.
    task automatic model_line(input int n);
        if (cap) begin
            if (n != 2 * H) exp_le = 1'b1;
            if (line_idx >= V) exp_fe = 1'b1;
            else begin
                for (int p = 0; p < H && 2 * p + 1 < n; p++) begin
                    int  g;
                    px_t e;
                    g = p / 2;
                    if (order == 1'b0) begin
                        e.y  = lb[2*p];
                        e.cb = lb[4*g+1];
                        e.cr = (p % 2 == 1) ? lb[4*g+3] : ((g == 0) ? 8'h80 : lb[4*g-1]);
                    end else begin
                        e.y  = lb[2*p+1];
                        e.cb = lb[4*g];
                        e.cr = (p % 2 == 1) ? lb[4*g+2] : ((g == 0) ? 8'h80 : lb[4*g-2]);
                    end
                    e.a = AW'(a0);
                    a0++;
                    q0.push_back(e);
                    if (p % 2 == 0 && line_idx % 2 == 0) begin
                        e.a = AW'(a1);
                        a1++;
                        q1.push_back(e);
                    end
                end
            end
            line_idx++;
        end
    endtask

    task automatic send_line(input int n);
        for (int i = 0; i < n; i++) begin
            href = 1'b1;
            d    = lb[i];
            tick();
        end
        href = 1'b0;
        d    = 8'd0;
        repeat (4) tick();
    endtask

    task automatic frame_begin(input bit c);
        cap = c;
        if (c) begin
            line_idx = 0;
            a0 = 0;
            a1 = 0;
            exp_le = 1'b0;
            exp_fe = 1'b0;
        end
        vsync = 1'b0;
        repeat (4) tick();
    endtask

    task automatic frame_end();
        repeat (2) tick();
        vsync = 1'b1;
        repeat (6) tick();
        if (cap) exp_fd++;
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_line_err0"}, le0, exp_le);
        chk({tag, "_line_err1"}, le1, exp_le);
        chk({tag, "_frame_err0"}, fe0, exp_fe);
        chk({tag, "_frame_err1"}, fe1, exp_fe);
        chk({tag, "_frame_done0"}, fdn0, exp_fd);
        chk({tag, "_frame_done1"}, fdn1, exp_fd);
        chk({tag, "_pending0"}, q0.size(), 0);
        chk({tag, "_pending1"}, q1.size(), 0);
    endtask

    initial begin
        mon_en = 1'b0;
        exp_fd = 0;
        fdn0 = 0;
        fdn1 = 0;
        fork
            forever begin
                @(negedge clk);
                if (mon_en) begin
                    if (bus0.pix_valid) begin
                        g0 = {bus0.Y, bus0.Cb, bus0.Cr, bus0.wr_addr};
                        cap0.push_back(g0);
                        if (q0.size() == 0) begin
                            n_chk++;
                            n_fail++;
                            $display("FAIL pix0_unexpected: got %0h, expected no pixel", g0);
                        end else chk("pix0", g0, q0.pop_front());
                    end
                    if (bus1.pix_valid) begin
                        g1 = {bus1.Y, bus1.Cb, bus1.Cr, bus1.wr_addr};
                        cap1.push_back(g1);
                        if (q1.size() == 0) begin
                            n_chk++;
                            n_fail++;
                            $display("FAIL pix1_unexpected: got %0h, expected no pixel", g1);
                        end else chk("pix1", g1, q1.pop_front());
                    end
                    if (fd0) fdn0++;
                    if (fd1) fdn1++;
                end
            end
        join_none

        // Reset in the middle of a line with HREF high.
        repeat (4) tick();
        rst_n = 1'b1;
        en = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (4) tick();
        fill(0);
        lb[0] = 8'd10; lb[1] = 8'd20; lb[2] = 8'd30;
        for (int i = 0; i < 3; i++) begin
            href = 1'b1;
            d = lb[i];
            tick();
        end
        d = 8'd40;
        rst_n = 1'b0;
        tick();
        chk("rst_pix_valid0", bus0.pix_valid, 0);
        chk("rst_pix_valid1", bus1.pix_valid, 0);
        chk("rst_busy0", busy0, 0);
        chk("rst_busy1", busy1, 0);
        chk("rst_wr_addr0", bus0.wr_addr, 0);
        chk("rst_wr_addr1", bus1.wr_addr, 0);
        chk("rst_Y0", bus0.Y, 0);
        chk("rst_line_err0", le0, 0);
        chk("rst_frame_err0", fe0, 0);
        chk("rst_line_err1", le1, 0);
        chk("rst_frame_err1", fe1, 0);
        chk("rst_frame_done0", fd0, 0);
        rst_n = 1'b1;
        href = 1'b0;
        repeat (4) tick();
        vsync = 1'b1;
        repeat (6) tick();
        chk("armed_busy0", busy0, 1);
        q0.delete();
        q1.delete();
        mon_en = 1'b1;

        // Byte order Y0 Cb Y1 Cr, one full line.
        order = 1'b0;
        base0 = cap0.size();
        frame_begin(1'b1);
        for (int i = 0; i < 8; i++) lb[i] = 8'(10 * (i + 1));
        model_line(8);
        chk("model_o0_p0", q0[0], {8'd10, 8'd20, 8'h80, 8'd0});
        chk("model_o0_p1", q0[1], {8'd30, 8'd20, 8'd40, 8'd1});
        chk("model_o0_p2", q0[2], {8'd50, 8'd60, 8'd40, 8'd2});
        chk("model_o0_p3", q0[3], {8'd70, 8'd60, 8'd80, 8'd3});
        chk("model_o0_dec_count", q1.size(), 2);
        send_line(8);
        frame_end();
        check_status("order0");
        chk("order0_count", cap0.size() - base0, 4);
        if (cap0.size() >= base0 + 4)
            chk("order0_dut_p3", cap0[base0+3], {8'd70, 8'd60, 8'd80, 8'd3});

        // Byte order Cb Y0 Cr Y1.
        order = 1'b1;
        frame_begin(1'b1);
        lb[0] = 8'd20; lb[1] = 8'd10; lb[2] = 8'd40; lb[3] = 8'd30;
        lb[4] = 8'd60; lb[5] = 8'd50; lb[6] = 8'd80; lb[7] = 8'd70;
        model_line(8);
        chk("model_o1_p0", q0[0], {8'd10, 8'd20, 8'h80, 8'd0});
        chk("model_o1_p1", q0[1], {8'd30, 8'd20, 8'd40, 8'd1});
        send_line(8);
        frame_end();
        check_status("order1");

        // Full 4x4 frame; the decimating instance keeps (0,0),(2,0),(0,2),(2,2).
        order = 1'b0;
        base0 = cap0.size();
        base1 = cap1.size();
        frame_begin(1'b1);
        for (int l = 0; l < V; l++) begin
            fill(l * 16 + 1);
            model_line(8);
            send_line(8);
        end
        frame_end();
        check_status("dec");
        chk("dec_full_count", cap0.size() - base0, 16);
        chk("dec_kept_count", cap1.size() - base1, 4);
        if (cap1.size() >= base1 + 4) begin
            chk("dec_p00", cap1[base1], {8'd1, 8'd2, 8'h80, 8'd0});
            chk("dec_p20_y", cap1[base1+1].y, 5);
            chk("dec_p20_a", cap1[base1+1].a, 1);
            chk("dec_p02_y", cap1[base1+2].y, 33);
            chk("dec_p02_a", cap1[base1+2].a, 2);
            chk("dec_p22", cap1[base1+3], {8'd37, 8'd38, 8'd36, 8'd3});
        end

        // Single shot with en held: second frame is ignored.
        ss = 1'b1;
        frame_begin(1'b1);
        fill(100);
        model_line(8);
        send_line(8);
        frame_end();
        check_status("ss_first");
        chk("ss_done_busy", busy0, 0);
        frame_begin(1'b0);
        fill(150);
        model_line(8);
        for (int i = 0; i < 8; i++) begin
            href = 1'b1;
            d = lb[i];
            tick();
        end
        chk("ss_second_busy0", busy0, 0);
        chk("ss_second_busy1", busy1, 0);
        href = 1'b0;
        repeat (4) tick();
        frame_end();
        check_status("ss_second");
        en = 1'b0;
        repeat (2) tick();
        ss = 1'b0;
        en = 1'b1;
        repeat (3) tick();
        chk("rearm_busy", busy0, 1);

        // Short first line and one line too many.
        frame_begin(1'b1);
        fill(1);
        model_line(6);
        send_line(6);
        for (int l = 1; l <= V; l++) begin
            fill(l * 16 + 1);
            model_line(8);
            send_line(8);
        end
        frame_end();
        check_status("err");
        chk("err_line_lit", le0, 1);
        chk("err_frame_lit", fe0, 1);
        frame_begin(1'b1);
        chk("err_clear_line", le0, 0);
        chk("err_clear_frame", fe1, 0);
        fill(200);
        model_line(8);
        send_line(8);
        frame_end();
        check_status("after_err");

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
